// File: rtl/icosoc_mod_pwmcap.sv
// PWM capture peripheral.
// Measures the period and the high time of an external waveform in clk cycles.
// Software reads the results through a small register bus.
//
// Ports:
//   clk        - sole clock, all state updates on the rising edge
//   resetn     - asynchronous active-low reset
//   ctrl_wr    - register write request
//   ctrl_rd    - register read request
//   ctrl_addr  - byte address of the register
//   ctrl_wdat  - write data
//   ctrl_rdat  - registered read data, nonzero only while ctrl_done is high
//   ctrl_done  - registered one-cycle access acknowledge
//   pin        - asynchronous waveform to measure
//
// Registers:
//   0x0 CTRL    [0] enable rw, [1] valid w1c, [2] overrun w1c, [3] timeout w1c,
//               [4] synchronized pin ro, [5] measuring ro
//   0x4 PERIOD  clocks between rising edges (ro)
//   0x8 HIGH    clocks from rising to falling edge (ro)
//   0xC TIMEOUT clock limit while measuring, 0 = no limit (rw)
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_IDLE    | capture disabled, cnt held at 0
// ST_ARM     | enabled, waiting for a rising edge to start counting
// ST_MEASURE | counting clocks since the last rising edge

module icosoc_mod_pwmcap #(
  parameter int CLOCK_FREQ_HZ = 6000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  input  logic        pin
);

  localparam logic [15:0] ADDR_CTRL    = 16'h0000;
  localparam logic [15:0] ADDR_PERIOD  = 16'h0004;
  localparam logic [15:0] ADDR_HIGH    = 16'h0008;
  localparam logic [15:0] ADDR_TIMEOUT = 16'h000C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  // CLOCK_FREQ_HZ only documents the intended clock; this empty block is its
  // sole reference and creates no hardware.
  if (CLOCK_FREQ_HZ <= 0) begin : g_clock_freq_unset
  end

  logic        pin_meta, pin_sync, pin_prev;
  logic        rise, fall;
  logic        req, wr_ctrl, wr_timeout;
  state_t      state, state_nxt;
  logic [31:0] cnt, high_tmp, period_q, high_q, timeout_q;
  logic        enable, valid, overrun, timeout_flag;
  logic        to_hit;
  logic        ev_start, ev_capture, ev_fall, ev_timeout;
  logic [31:0] rd_mux;

  // Two flops against metastability, a third to detect edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pin_meta <= 1'b0;
      pin_sync <= 1'b0;
      pin_prev <= 1'b0;
    end else begin
      pin_meta <= pin;
      pin_sync <= pin_meta;
      pin_prev <= pin_sync;
    end
  end

  assign rise = pin_sync & ~pin_prev;
  assign fall = ~pin_sync & pin_prev;

  // A request is taken only while no acknowledge is pending.
  assign req        = (ctrl_wr | ctrl_rd) & ~ctrl_done;
  assign wr_ctrl    = req & ctrl_wr & (ctrl_addr == ADDR_CTRL);
  assign wr_timeout = req & ctrl_wr & (ctrl_addr == ADDR_TIMEOUT);

  assign to_hit = (timeout_q != '0) && (cnt == timeout_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_ARM;
        ST_ARM:     if (rise) state_nxt = ST_MEASURE;
        ST_MEASURE: if (to_hit) state_nxt = ST_ARM;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Timeout wins over an edge in the same cycle: the limit has been reached.
  always_comb begin
    ev_start   = 1'b0;
    ev_capture = 1'b0;
    ev_fall    = 1'b0;
    ev_timeout = 1'b0;
    if (enable) begin
      case (state)
        ST_ARM: ev_start = rise;
        ST_MEASURE: begin
          if (to_hit)    ev_timeout = 1'b1;
          else if (rise) ev_capture = 1'b1;
          else if (fall) ev_fall    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      high_tmp <= '0;
      period_q <= '0;
      high_q   <= '0;
    end else begin
      if (!enable)                      cnt <= '0;
      else if (ev_start || ev_capture)  cnt <= 32'd1;
      else if (ev_timeout)              cnt <= '0;
      else if (state == ST_MEASURE && cnt != '1) cnt <= cnt + 32'd1;

      if (ev_fall) high_tmp <= cnt;

      if (ev_capture) begin
        period_q <= cnt;
        high_q   <= high_tmp;
      end else if (ev_timeout) begin
        period_q <= '0;
        high_q   <= '0;
      end
    end
  end

  // Hardware set beats a software clear in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable       <= 1'b0;
      valid        <= 1'b0;
      overrun      <= 1'b0;
      timeout_flag <= 1'b0;
      timeout_q    <= '0;
    end else begin
      if (wr_ctrl)    enable <= ctrl_wdat[0];
      if (wr_timeout) timeout_q <= ctrl_wdat;
      valid        <= ev_capture | (valid & ~(wr_ctrl & ctrl_wdat[1]));
      overrun      <= (ev_capture & valid) | (overrun & ~(wr_ctrl & ctrl_wdat[2]));
      timeout_flag <= ev_timeout | (timeout_flag & ~(wr_ctrl & ctrl_wdat[3]));
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ctrl_addr)
      ADDR_CTRL:    rd_mux = {26'd0, state == ST_MEASURE, pin_sync,
                              timeout_flag, overrun, valid, enable};
      ADDR_PERIOD:  rd_mux = period_q;
      ADDR_HIGH:    rd_mux = high_q;
      ADDR_TIMEOUT: rd_mux = timeout_q;
      default:      rd_mux = '0;
    endcase
  end

  // Read data is sampled from pre-write state, so a combined write+read
  // returns the old value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
    end else begin
      ctrl_done <= req;
      ctrl_rdat <= (req && ctrl_rd) ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_icosoc_mod_pwmcap.sv
module tb_icosoc_mod_pwmcap;

  localparam int HI = 40;
  localparam int LO = 60;

  logic        clk;
  logic        resetn;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic        pin;

  logic pwm_on, pwm_pin, man_pin;
  int   ph;
  int   n_chk, n_err;

  assign pin = pwm_on ? pwm_pin : man_pin;

  icosoc_mod_pwmcap #(.CLOCK_FREQ_HZ(6000000)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ctrl_wr   (ctrl_wr),
    .ctrl_rd   (ctrl_rd),
    .ctrl_addr (ctrl_addr),
    .ctrl_wdat (ctrl_wdat),
    .ctrl_rdat (ctrl_rdat),
    .ctrl_done (ctrl_done),
    .pin       (pin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Measurement is expressed with time stamps: the cycle index of the last
  // rising edge, and elapsed clocks since it.
  int          cyc, t_rise, mode;          // mode: 0 off, 1 waiting, 2 measuring
  logic [2:0]  m_pipe;                     // pin samples: [0] newest
  logic [31:0] m_period, m_high, m_high_tmp, m_to, m_rdat, el;
  logic        m_en, m_valid, m_ovr, m_tof, m_done;
  logic        m_rise, m_fall, m_req, set_v, set_o, set_t, w_ctrl;

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      16'h0: r = {26'd0, mode == 2, m_pipe[1], m_tof, m_ovr, m_valid, m_en};
      16'h4: r = m_period;
      16'h8: r = m_high;
      16'hC: r = m_to;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        cyc = 0; t_rise = 0; mode = 0; m_pipe = 3'b000;
        m_period = 0; m_high = 0; m_high_tmp = 0; m_to = 0; m_rdat = 0;
        m_en = 0; m_valid = 0; m_ovr = 0; m_tof = 0; m_done = 0;
      end else begin
        m_rise = m_pipe[1] & ~m_pipe[2];
        m_fall = ~m_pipe[1] & m_pipe[2];
        m_req  = (ctrl_wr | ctrl_rd) & ~m_done;
        m_rdat = (m_req && ctrl_rd) ? m_read(ctrl_addr) : 32'd0;
        m_done = m_req;
        set_v = 0; set_o = 0; set_t = 0;
        el = 32'(cyc - t_rise);
        if (!m_en) mode = 0;
        else if (mode == 0) mode = 1;
        else if (mode == 1) begin
          if (m_rise) begin mode = 2; t_rise = cyc; end
        end else begin
          if (m_to != 0 && el == m_to) begin
            set_t = 1; m_period = 0; m_high = 0; mode = 1;
          end else if (m_rise) begin
            set_v = 1; set_o = m_valid; m_period = el; m_high = m_high_tmp; t_rise = cyc;
          end else if (m_fall) begin
            m_high_tmp = el;
          end
        end
        w_ctrl  = m_req && ctrl_wr && ctrl_addr == 16'h0;
        m_valid = set_v | (m_valid & ~(w_ctrl & ctrl_wdat[1]));
        m_ovr   = set_o | (m_ovr & ~(w_ctrl & ctrl_wdat[2]));
        m_tof   = set_t | (m_tof & ~(w_ctrl & ctrl_wdat[3]));
        if (w_ctrl) m_en = ctrl_wdat[0];
        if (m_req && ctrl_wr && ctrl_addr == 16'hC) m_to = ctrl_wdat;
        m_pipe = {m_pipe[1:0], pin};
        cyc++;
      end
    end
  end

  // Every-cycle comparison of the bus outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        chk("cyc_done", 32'(ctrl_done), 32'(m_done));
        chk("cyc_rdat", ctrl_rdat, m_rdat);
      end
    end
  end

  // PWM source: HI clocks high, LO clocks low, changing on falling clk edges.
  initial begin
    pwm_pin = 1'b0;
    ph = 0;
    forever begin
      @(negedge clk);
      if (!pwm_on) ph = 0;
      else begin
        pwm_pin = (ph < HI);
        ph = (ph == HI + LO - 1) ? 0 : ph + 1;
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus(input logic wr, input logic rd, input logic [15:0] a,
                     input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    ctrl_wr = wr; ctrl_rd = rd; ctrl_addr = a; ctrl_wdat = d;
    @(negedge clk);
    chk("ack", 32'(ctrl_done), 32'd1);
    r = ctrl_rdat;
    ctrl_wr = 0; ctrl_rd = 0; ctrl_addr = 0; ctrl_wdat = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, 1'b0, a, d, r);
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r;
    bus(1'b0, 1'b1, a, 32'd0, r);
    chk(name, r, exp);
  endtask

  task automatic pin_steps(input logic lvl, input int n);
    man_pin = lvl;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    n_chk = 0; n_err = 0;
    resetn = 0; ctrl_wr = 0; ctrl_rd = 0; ctrl_addr = 0; ctrl_wdat = 0;
    pwm_on = 0; man_pin = 0;
    repeat (3) @(negedge clk);
    resetn = 1;

    rd_chk(16'h0, 32'h0, "rst_ctrl");
    rd_chk(16'h4, 32'h0, "rst_period");
    rd_chk(16'h8, 32'h0, "rst_high");
    rd_chk(16'hC, 32'h0, "rst_timeout");
    wr(16'hC, 32'h1234_5678);
    rd_chk(16'hC, 32'h1234_5678, "timeout_rw");
    wr(16'h4, 32'h0000_dead);
    rd_chk(16'h4, 32'h0, "period_ro");
    wr(16'hC, 32'h0);

    // 40 high / 60 low, two rising edges seen
    wr(16'h0, 32'h1);
    repeat (4) @(negedge clk);
    pwm_on = 1;
    repeat (150) @(negedge clk);
    rd_chk(16'h0, 32'h23, "ctrl_valid");
    rd_chk(16'h4, 32'd100, "period_100");
    rd_chk(16'h8, 32'd40, "high_40");

    // two more periods without clearing valid
    repeat (200) @(negedge clk);
    rd_chk(16'h0, 32'h27, "ctrl_overrun");
    wr(16'h0, 32'h7);
    rd_chk(16'h0, 32'h21, "ctrl_w1c");

    // timeout with pin held high
    man_pin = 0;
    pwm_on = 0;
    wr(16'h0, 32'h0);
    wr(16'hC, 32'd50);
    wr(16'h0, 32'hF);
    repeat (5) @(negedge clk);
    pin_steps(1'b1, 70);
    rd_chk(16'h0, 32'h19, "ctrl_timeout");
    rd_chk(16'h4, 32'h0, "period_timeout");
    rd_chk(16'h8, 32'h0, "high_timeout");

    // combined write+read returns the old value
    bus(1'b1, 1'b1, 16'hC, 32'd0, r);
    chk("wr_rd_old", r, 32'd50);
    rd_chk(16'hC, 32'd0, "wr_rd_new");

    // rising edge coincident with w1c of valid
    wr(16'h0, 32'hF);
    pin_steps(1'b0, 5);
    pin_steps(1'b1, 10);
    pin_steps(1'b0, 10);
    pin_steps(1'b1, 5);
    pin_steps(1'b0, 15);
    man_pin = 1;
    @(negedge clk);
    @(negedge clk);
    ctrl_wr = 1; ctrl_addr = 16'h0; ctrl_wdat = 32'h3;
    @(negedge clk);
    chk("ack_coinc", 32'(ctrl_done), 32'd1);
    ctrl_wr = 0; ctrl_wdat = 0;
    rd_chk(16'h0, 32'h37, "ctrl_coincident");
    rd_chk(16'h4, 32'd20, "period_20");
    rd_chk(16'h8, 32'd5, "high_5");
    rd_chk(16'h10, 32'h0, "unmapped");

    // held request: acknowledged every other cycle
    @(negedge clk);
    ctrl_rd = 1; ctrl_addr = 16'h4;
    @(negedge clk);
    chk("hold_ack1", 32'(ctrl_done), 32'd1);
    chk("hold_rdat1", ctrl_rdat, 32'd20);
    @(negedge clk);
    chk("hold_gap", 32'(ctrl_done), 32'd0);
    chk("hold_gap_rdat", ctrl_rdat, 32'd0);
    @(negedge clk);
    chk("hold_ack2", 32'(ctrl_done), 32'd1);
    ctrl_rd = 0; ctrl_addr = 0;
    @(negedge clk);
    chk("hold_end", 32'(ctrl_done), 32'd0);

    // asynchronous reset while measuring
    @(negedge clk);
    ctrl_rd = 1; ctrl_addr = 16'h4;
    @(posedge clk);
    #2;
    chk("pre_rst_done", 32'(ctrl_done), 32'd1);
    resetn = 0;
    #1;
    chk("rst_async_done", 32'(ctrl_done), 32'd0);
    chk("rst_async_rdat", ctrl_rdat, 32'd0);
    ctrl_rd = 0; ctrl_addr = 0;
    repeat (3) @(negedge clk);
    resetn = 1;
    repeat (3) @(negedge clk);
    rd_chk(16'h0, 32'h10, "rst2_ctrl");
    rd_chk(16'h4, 32'h0, "rst2_period");
    rd_chk(16'h8, 32'h0, "rst2_high");
    rd_chk(16'hC, 32'h0, "rst2_timeout");

    // edges while disabled are not captured
    pin_steps(1'b0, 10);
    pin_steps(1'b1, 10);
    pin_steps(1'b0, 10);
    pin_steps(1'b1, 10);
    rd_chk(16'h4, 32'h0, "no_capture_disabled");

    // re-enabled: 12 high / 18 low
    wr(16'h0, 32'h1);
    pin_steps(1'b0, 10);
    pin_steps(1'b1, 12);
    pin_steps(1'b0, 18);
    pin_steps(1'b1, 12);
    pin_steps(1'b0, 18);
    pin_steps(1'b1, 5);
    rd_chk(16'h4, 32'd30, "period_30");
    rd_chk(16'h8, 32'd12, "high_12");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/icosoc_mod_pwmcap.md
ICOSOC_MOD_PWMCAP -- requirements
Module: icosoc_mod_pwmcap

Interface
REQ-001 SHALL have parameter CLOCK_FREQ_HZ, default 6000000, informational only with no effect on logic.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ctrl_wr  input  1  register write request.
REQ-005 SHALL have port ctrl_rd  input  1  register read request.
REQ-006 SHALL have port ctrl_addr  input  16  byte address of register.
REQ-007 SHALL have port ctrl_wdat  input  32  write data.
REQ-008 SHALL have port ctrl_rdat  output  32  read data, registered.
REQ-009 SHALL have port ctrl_done  output  1  one-cycle access acknowledge, registered.
REQ-010 SHALL have port pin  input  1  asynchronous PWM waveform to measure, e.g. from a PWM generator output.

Function
REQ-011 SHALL pass pin through a 2-flop synchronizer, then one more flop for edge detection; rise = sync & !prev, fall = !sync & prev.
REQ-012 SHALL implement states IDLE, ARM, MEASURE; IDLE while CTRL.enable=0, ARM on enable 0->1, ARM->MEASURE on rise.
REQ-013 SHALL, on rise in ARM, load cnt=1; in MEASURE each non-rise cycle cnt <= cnt+1, saturating at 0xFFFFFFFF.
REQ-014 SHALL, on fall in MEASURE, capture high_tmp <= cnt.
REQ-015 SHALL, on rise in MEASURE, load PERIOD <= cnt, HIGH <= high_tmp, set valid, reload cnt=1; result: PERIOD = clocks between rising edges, HIGH = clocks from rise to fall.
REQ-016 SHALL set overrun when REQ-015 updates while valid is already 1; registers still update.
REQ-017 SHALL, when TIMEOUT != 0 and cnt == TIMEOUT in MEASURE, set timeout flag, write PERIOD=0 and HIGH=0, and go to ARM; TIMEOUT=0 disables timeout.
REQ-018 SHALL, when enable is cleared, go to IDLE within one cycle, cnt=0; PERIOD, HIGH, flags retained.
REQ-019 SHALL map registers: 0x0 CTRL, 0x4 PERIOD (ro), 0x8 HIGH (ro), 0xC TIMEOUT (rw, 32 bit).
REQ-020 SHALL define CTRL bits: [0] enable rw, [1] valid w1c, [2] overrun w1c, [3] timeout w1c, [4] synchronized pin level ro, [5] 1 when state==MEASURE ro, others read 0.
REQ-021 SHALL, when hardware sets a flag in the same cycle software writes 1 to clear it, leave the flag set.
REQ-022 SHALL assert ctrl_done for exactly one cycle, the cycle after a request sampled while ctrl_done=0; requests while ctrl_done=1 are ignored.
REQ-023 SHALL present read data on ctrl_rdat in the ctrl_done cycle and drive 0 at all other times.
REQ-024 SHALL, on simultaneous ctrl_wr and ctrl_rd, perform both with one ctrl_done; read returns pre-write value.
REQ-025 SHALL acknowledge unmapped addresses normally: writes ignored, reads return 0; writes to PERIOD/HIGH ignored.

Reset
REQ-026 SHALL, on resetn low, immediately clear: state IDLE, cnt, high_tmp, PERIOD, HIGH, TIMEOUT, all flags, enable, synchronizer flops, ctrl_done=0, ctrl_rdat=0.
REQ-027 SHALL resume measurement after reset only after software sets enable and a fresh rise is seen in ARM.

Verification
REQ-028 SHALL verify: enable, pin 40 clocks high / 60 low repeated -> after second rise PERIOD=100, HIGH=40, valid=1, ctrl_done one cycle per access.
REQ-029 SHALL verify: two further periods without clearing valid -> overrun=1; write CTRL=0x7 -> valid=0, overrun=0, enable=1.
REQ-030 SHALL verify: TIMEOUT=50, pin held high after rise -> timeout=1, PERIOD=0, HIGH=0, state ARM (CTRL[5]=0).
REQ-031 SHALL verify: rise coincident with w1c of valid -> valid reads 1; read of 0x10 -> 0 with ctrl_done.
REQ-032 SHALL verify: resetn asserted mid-MEASURE -> all outputs/registers 0 without a clock edge; no capture until re-enabled and rise seen.
